// File: rtl/ewb_drain.sv
// ewb_drain: pops dirty lines from the L2 eviction write buffer and writes each one to memory as a burst.
// Optional EWB_DRAIN_STATS_EN adds saturating drained-line and forced-drain counters.
//   state | meaning
//   IDLE  | waiting for an EWB entry and a free memory port
//   BURST | writing the held line one beat per accepted response
//   DONE  | single idle cycle after the last beat
module ewb_drain #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32,
  parameter int OFS_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ewb_empty_i,
  input  logic                    ewb_full_i,
  input  logic [LINE_W-1:0]       ewb_data_i,
  input  logic [ADDR_W-1:0]       ewb_addr_i,
  output logic                    ewb_yumi_o,
  input  logic                    rd_req_i,
  output logic                    wr_busy_o,
  input  logic                    tag_check_i,
  input  logic [ADDR_W-OFS_W-1:0] tag_i,
  output logic                    hit_o,
  output logic [LINE_W-1:0]       hit_data_o,
  output logic                    pmem_write_o,
  output logic [ADDR_W-1:0]       pmem_address_o,
  output logic [BEAT_W-1:0]       pmem_wdata_o,
  input  logic                    pmem_resp_i
`ifdef EWB_DRAIN_STATS_EN
  ,
  output logic [31:0]             lines_drained_o,
  output logic [15:0]             forced_drains_o
`endif
);

  localparam int BEAT_IW = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS_W) - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t              state, state_next;
  logic [BEAT_IW-1:0]  beat;
  logic [LINE_W-1:0]   line;
  logic [ADDR_W-1:0]   addr;
  logic [BEAT_W-1:0]   beat_data;
  logic                start;
  logic                last_beat;

  // A pop while reset is held would be lost, so reset masks the handshake.
  assign start     = (state == IDLE) && !rst && !ewb_empty_i && (!rd_req_i || ewb_full_i);
  assign last_beat = (beat == BEAT_IW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      line  <= '0;
      addr  <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        line <= ewb_data_i;
        addr <= ewb_addr_i & ~OFS_MASK;
        beat <= '0;
      end else if (state == BURST && pmem_resp_i) begin
        beat <= beat + BEAT_IW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BURST;
      BURST:   if (pmem_resp_i && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < BEATS; i++)
      if (beat == BEAT_IW'(i)) beat_data = line[i*BEAT_W +: BEAT_W];
  end

  assign ewb_yumi_o     = start;
  assign wr_busy_o      = (state != IDLE);
  assign pmem_write_o   = (state == BURST);
  assign pmem_address_o = (state == BURST) ? addr : '0;
  assign pmem_wdata_o   = (state == BURST) ? beat_data : '0;

  // The EWB covers the pop cycle; from the next cycle the held line answers probes.
  assign hit_o      = tag_check_i && (state != IDLE) && (addr[ADDR_W-1:OFS_W] == tag_i);
  assign hit_data_o = hit_o ? line : '0;

`ifdef EWB_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lines_drained_o <= '0;
      forced_drains_o <= '0;
    end else begin
      if (state == DONE && lines_drained_o != '1)
        lines_drained_o <= lines_drained_o + 32'd1;
      if (start && rd_req_i && ewb_full_i && forced_drains_o != '1)
        forced_drains_o <= forced_drains_o + 16'd1;
    end
  end
`endif

endmodule
